// File: rtl/bram_arbiter.sv
// Two-port round-robin arbiter with bounded burst lock in front of a single-port
// 32-bit block RAM; returns a registered ack and read data one cycle after acceptance.
module bram_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [31:0]           wdata0,
    input  logic [31:0]           wdata1,
    input  logic [3:0]            we0,
    input  logic [3:0]            we1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [31:0]           rdata0,
    output logic [31:0]           rdata1,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [31:0]           ram_dina,
    output logic [3:0]            ram_wea,
    input  logic [31:0]           ram_douta
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_e;

    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    owner_e     owner_q, owner_d;
    logic       last_q, last_d;          // 1 = port 1 won most recently
    logic [7:0] bcnt_q, bcnt_d;
    logic       ack_pend0_q, ack_pend1_q;

    logic [1:0] req_v, lock_v;
    logic       owned, own_sel;
    logic       win_valid, win_sel, fresh_win;

    assign req_v   = {req1, req0};
    assign lock_v  = {lock1, lock0};
    assign owned   = (owner_q != OWN_NONE);
    assign own_sel = (owner_q == OWN_P1);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        owner_d   = owner_q;
        last_d    = last_q;
        bcnt_d    = bcnt_q;
        win_valid = 1'b0;
        win_sel   = 1'b0;
        fresh_win = 1'b0;

        if (owned && req_v[own_sel] && lock_v[own_sel]) begin
            win_valid = 1'b1;
            if (!req_v[~own_sel] || (bcnt_q < BURST_MAX)) begin
                win_sel = own_sel;
                bcnt_d  = (bcnt_q < BURST_MAX) ? bcnt_q + 8'd1 : bcnt_q;
            end else begin
                // Burst cap reached with the other port waiting: hand over once.
                win_sel   = ~own_sel;
                fresh_win = 1'b1;
            end
        end else if (req_v != 2'b00) begin
            win_valid = 1'b1;
            win_sel   = (req_v == 2'b11) ? ~last_q : req_v[1];
            fresh_win = 1'b1;
        end else begin
            owner_d = OWN_NONE;
            bcnt_d  = 8'd0;
        end

        if (fresh_win) begin
            last_d = win_sel;
            if (lock_v[win_sel]) begin
                owner_d = win_sel ? OWN_P1 : OWN_P0;
                bcnt_d  = 8'd1;
            end else begin
                owner_d = OWN_NONE;
                bcnt_d  = 8'd0;
            end
        end
    end

    assign gnt0 = ~rsta & win_valid & ~win_sel;
    assign gnt1 = ~rsta & win_valid &  win_sel;

    assign ram_addra = gnt1 ? addr1  : addr0;
    assign ram_dina  = gnt1 ? wdata1 : wdata0;
    assign ram_wea   = gnt0 ? we0 : (gnt1 ? we1 : 4'b0000);

    // NOTE: reset is synchronous, so it lives inside the clocked block, not its sensitivity list.
    always_ff @(posedge clka) begin
        if (rsta) begin
            owner_q     <= OWN_NONE;
            last_q      <= 1'b1;
            bcnt_q      <= 8'd0;
            ack_pend0_q <= 1'b0;
            ack_pend1_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            last_q      <= last_d;
            bcnt_q      <= bcnt_d;
            ack_pend0_q <= req0 & gnt0;
            ack_pend1_q <= req1 & gnt1;
        end
    end

    // Masked by reset so an ack already in flight when reset hits is discarded.
    assign ack0   = ack_pend0_q & ~rsta;
    assign ack1   = ack_pend1_q & ~rsta;
    assign rdata0 = ack0 ? ram_douta : 32'd0;
    assign rdata1 = ack1 ? ram_douta : 32'd0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural read-first RAM and MAX_BURST=4.
module tb_bram_arbiter;

    localparam int AW = 14;
    localparam int MB = 4;

    logic          clka = 1'b0;
    logic          rsta;
    logic          req0, req1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [31:0]   wdata0, wdata1;
    logic [3:0]    we0, we1;
    logic          gnt0, gnt1, ack0, ack1;
    logic [31:0]   rdata0, rdata1;
    logic [AW-1:0] ram_addra;
    logic [31:0]   ram_dina;
    logic [3:0]    ram_wea;
    logic [31:0]   ram_douta;

    always #5 clka = ~clka;

    bram_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clka(clka), .rsta(rsta),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
        .ram_douta(ram_douta)
    );

    // Single-port RAM, registered read returning the pre-write word.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clka) begin
        ram_douta <= mem[ram_addra];
        for (int b = 0; b < 4; b++)
            if (ram_wea[b]) mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
    end

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clka);
        #1;
    endtask

    task automatic smp();
        @(negedge clka);
    endtask

    task automatic idle();
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        we0 = 4'h0; we1 = 4'h0;
    endtask

    logic [10:0] burst_pat;
    logic [8:0]  rel_pat;
    int          wait_cnt, max_wait;

    initial begin
        idle();
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset held 3 cycles with both ports requesting and a write pending.
        rsta = 1'b1; req0 = 1'b1; req1 = 1'b1;
        we0 = 4'hF; addr0 = 14'h0100; wdata0 = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            smp();
            check("rst_gnt",   32'({gnt0, gnt1}), 32'd0);
            check("rst_wea",   32'(ram_wea), 32'd0);
            check("rst_ack",   32'({ack0, ack1}), 32'd0);
            check("rst_rdata", rdata0 | rdata1, 32'd0);
            cyc();
        end

        // First cycle after reset: port 0 wins the tie.
        rsta = 1'b0; we0 = 4'h0; addr0 = 14'h0010;
        smp();
        check("post_rst_gnt", 32'({gnt0, gnt1}), 32'b10);
        check("post_rst_ack", 32'({ack0, ack1}), 32'd0);
        cyc();

        // Preload two words through port 0.
        req1 = 1'b0; we0 = 4'hF; addr0 = 14'h0010; wdata0 = 32'hDEADBEEF;
        smp();
        check("pre1_gnt0", 32'(gnt0), 32'd1);
        check("post_rst_ack0", 32'(ack0), 32'd1);
        cyc();
        addr0 = 14'h0020; wdata0 = 32'h11223344;
        smp();
        check("pre2_gnt0", 32'(gnt0), 32'd1);
        check("pre2_wea",  32'(ram_wea), 32'hF);
        cyc();

        // Read latency on port 0.
        we0 = 4'h0; addr0 = 14'h0010;
        smp();
        check("rd_gnt0",  32'(gnt0), 32'd1);
        check("rd_wea",   32'(ram_wea), 32'd0);
        check("rd_addra", 32'(ram_addra), 32'h10);
        cyc();
        idle();
        smp();
        check("rd_ack0",   32'(ack0), 32'd1);
        check("rd_rdata0", rdata0, 32'hDEADBEEF);
        check("rd_ack1",   32'(ack1), 32'd0);
        check("rd_rdata1", rdata1, 32'd0);
        cyc();

        // Byte write on port 1, then read back.
        req1 = 1'b1; we1 = 4'b0100; addr1 = 14'h0020; wdata1 = 32'h00AB0000;
        smp();
        check("bw_gnt",   32'({gnt0, gnt1}), 32'b01);
        check("bw_wea",   32'(ram_wea), 32'h4);
        check("bw_addra", 32'(ram_addra), 32'h20);
        check("bw_dina",  ram_dina, 32'h00AB0000);
        cyc();
        we1 = 4'h0;
        smp();
        check("bw_ack1",   32'(ack1), 32'd1);
        check("bw_old",    rdata1, 32'h11223344);
        check("bw_rdgnt1", 32'(gnt1), 32'd1);
        cyc();
        idle();
        smp();
        check("bw_rd_ack1", 32'(ack1), 32'd1);
        check("bw_new",     rdata1, 32'h11AB3344);
        cyc();

        // Round robin: last winner is port 1, so port 0 goes first.
        req0 = 1'b1; req1 = 1'b1; addr0 = 14'h0010; addr1 = 14'h0020;
        for (int i = 0; i < 6; i++) begin
            smp();
            check($sformatf("rr_gnt_%0d", i), 32'({gnt0, gnt1}), (i % 2 == 0) ? 32'b10 : 32'b01);
            if (i > 0) begin
                check($sformatf("rr_ack_%0d", i), 32'({ack0, ack1}), (i % 2 == 1) ? 32'b10 : 32'b01);
                check($sformatf("rr_rdata_%0d", i), rdata0 | rdata1,
                      (i % 2 == 1) ? 32'hDEADBEEF : 32'h11AB3344);
            end
            cyc();
        end
        idle();
        smp();
        check("rr_last_ack",   32'({ack0, ack1}), 32'b01);
        check("rr_last_rdata", rdata1, 32'h11AB3344);
        cyc();

        // Burst cap: port 1 locked, port 0 plain, both requesting throughout.
        burst_pat = 11'b01111011110;
        wait_cnt = 0; max_wait = 0;
        req0 = 1'b1; req1 = 1'b1; lock1 = 1'b1;
        for (int i = 0; i < 11; i++) begin
            smp();
            check($sformatf("burst_gnt_%0d", i), 32'({gnt0, gnt1}),
                  burst_pat[i] ? 32'b01 : 32'b10);
            if (gnt0) wait_cnt = 0;
            else begin
                wait_cnt++;
                if (wait_cnt > max_wait) max_wait = wait_cnt;
            end
            cyc();
        end
        check("burst_max_wait", 32'(max_wait), 32'd4);
        idle();
        smp();
        check("burst_end_ack0", 32'(ack0), 32'd1);
        cyc();

        // Lock release: lock0 drops in cycle 3, then a fresh locked burst from bcnt=1.
        rel_pat = 9'b100001000;
        for (int i = 0; i < 9; i++) begin
            req0  = 1'b1;
            lock0 = (i != 3);
            req1  = (i >= 1);
            smp();
            check($sformatf("rel_gnt_%0d", i), 32'({gnt0, gnt1}),
                  rel_pat[i] ? 32'b01 : 32'b10);
            cyc();
        end
        idle();
        cyc();

        // Reset mid-burst drops the lock and discards the pending ack.
        req1 = 1'b1; lock1 = 1'b1;
        smp();
        check("mrst_start_gnt", 32'({gnt0, gnt1}), 32'b01);
        cyc();
        req0 = 1'b1; rsta = 1'b1;
        smp();
        check("mrst_gnt",   32'({gnt0, gnt1}), 32'd0);
        check("mrst_wea",   32'(ram_wea), 32'd0);
        check("mrst_ack",   32'({ack0, ack1}), 32'd0);
        check("mrst_rdata", rdata1, 32'd0);
        cyc();
        rsta = 1'b0;
        smp();
        check("mrst_after_gnt", 32'({gnt0, gnt1}), 32'b10);
        check("mrst_after_ack", 32'({ack0, ack1}), 32'd0);
        cyc();
        idle();
        cyc();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
